// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch unit bundle: control inputs, instruction-memory port and decode-side stream
interface fetch_queue_if #(
  parameter int XLEN       = 64,
  parameter int ADDR_WIDTH = 10
);
  logic                  fetch_en;
  logic                  redirect_valid;
  logic [XLEN-1:0]       redirect_pc;
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_pc;
  logic [31:0]           out_instr;
  logic                  out_misalign;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_pc, out_instr, out_misalign
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_pc, out_instr, out_misalign
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC, 1-cycle imem requests and instruction FIFO toward decode
// Optional FETCH_MISALIGN_CHECK_EN: halt and flag on misaligned redirect targets.
module fetch_queue #(
  parameter int              XLEN       = 64,
  parameter int              ADDR_WIDTH = 10,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               rst,
  fetch_queue_if.master      bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic [XLEN-1:0] q_pc    [FIFO_DEPTH];
  logic [31:0]     q_instr [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            halted;
  logic [XLEN-1:0] redirect_target;
  logic [CW:0]     credits_used;
  logic            issue;
  logic            pop;
  logic            push;

  // Queued entries plus the outstanding request must fit, so a response never meets a full FIFO.
  assign credits_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue = !rst && bus.fetch_en && !bus.redirect_valid && !halted &&
                 (credits_used < (CW+1)'(FIFO_DEPTH));

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc[ADDR_WIDTH+1:2];
  assign bus.out_valid = !rst && (count != '0);
  assign bus.out_pc    = q_pc[rd_ptr];
  assign bus.out_instr = q_instr[rd_ptr];

  assign pop  = bus.out_valid && bus.out_ready;
  assign push = inflight;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_target  = bus.redirect_pc;
  assign bus.out_misalign = halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (bus.redirect_valid) begin
      halted <= |bus.redirect_pc[1:0];
    end
  end
`else
  assign redirect_target  = bus.redirect_pc & ~XLEN'(3);
  assign bus.out_misalign = 1'b0;
  assign halted           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst && !bus.redirect_valid && push) begin
      q_pc[wr_ptr]    <= req_pc;
      q_instr[wr_ptr] <= bus.imem_rdata;
    end
  end

  // Redirect outranks everything except reset: the response in flight is simply never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= redirect_target;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CW'(push) - CW'(pop);
      inflight <= issue;
      if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + XLEN'(4);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - vector table, directed corner sequences and randomized stream check for fetch_queue
module tb_fetch_queue;
  localparam int          XLEN  = 64;
  localparam int          AW    = 10;
  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h0;

  logic clk;
  logic rst;
  logic [31:0] rdata;
  int n_cmp;
  int n_fail;

  fetch_queue_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) bus();

  fetch_queue #(
    .XLEN(XLEN), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word n holds A000_0000 + n.
  always @(posedge clk) if (bus.imem_req) rdata <= 32'hA000_0000 + 32'(bus.imem_addr);
  assign bus.imem_rdata = rdata;

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        ev;
    logic        er;
    logic [9:0]  ea;
    logic [63:0] epc;
  } vec_t;

  vec_t tbl [21];

  function automatic logic [31:0] word_of(input logic [63:0] pc);
    return 32'hA000_0000 + 32'(pc[11:2]);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: inputs applied just after the edge, returns at the falling edge for sampling.
  task automatic cyc(input logic r, input logic fe, input logic rdy, input logic rv,
                     input logic [63:0] rpc);
    @(posedge clk);
    #1;
    rst                = r;
    bus.fetch_en       = fe;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #4;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_req", 64'(bus.imem_req), 64'd0);
    chk("rst_misalign", 64'(bus.out_misalign), 64'd0);
  endtask

  task automatic chk_head(input string name, input logic [63:0] pc);
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_pc"}, bus.out_pc, pc);
    chk({name, "_instr"}, 64'(bus.out_instr), 64'(word_of(pc)));
  endtask

  initial begin
    logic [63:0] exp_pc;
    logic [63:0] prev_pc;
    logic        stall_prev;
    logic        r, fe, rdy, rv;
    logic [63:0] rpc;
    int          n_acc;

    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.fetch_en = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 10'd0,  64'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 10'd1,  64'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd2,  64'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd3,  64'h4};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd4,  64'h8};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd5,  64'hC};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd6,  64'h10};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd7,  64'h10};
    for (int i = 8; i < 16; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 64'h10};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 10'd0,  64'h10};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd8,  64'h14};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd9,  64'h18};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd10, 64'h1C};
    tbl[20] = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd11, 64'h20};

    // Startup latency, streaming, 10-cycle backpressure until credits run out, then drain.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      cyc(1'b0, tbl[i].fe, tbl[i].rdy, 1'b0, 64'd0);
      chk($sformatf("tbl%0d_valid", i), 64'(bus.out_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_req", i), 64'(bus.imem_req), 64'(tbl[i].er));
      if (tbl[i].er) chk($sformatf("tbl%0d_addr", i), 64'(bus.imem_addr), 64'(tbl[i].ea));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), bus.out_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_instr", i), 64'(bus.out_instr), 64'(word_of(tbl[i].epc)));
      end
    end

    // Redirect with three entries queued and one request in flight.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 64'h100);
    chk_head("rdA_c4", 64'h0);
    chk("rdA_c4_req", 64'(bus.imem_req), 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    chk("rdA_c5_valid", 64'(bus.out_valid), 64'd0);
    chk("rdA_c5_req", 64'(bus.imem_req), 64'd1);
    chk("rdA_c5_addr", 64'(bus.imem_addr), 64'h40);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    chk("rdA_c6_valid", 64'(bus.out_valid), 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk_head("rdA_c7", 64'h100);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk_head("rdA_c8", 64'h104);

    // Redirect coinciding with a head handshake and an arriving response.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 64'h200);
    chk_head("rdB_c4", 64'h8);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk("rdB_c5_valid", 64'(bus.out_valid), 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk("rdB_c6_valid", 64'(bus.out_valid), 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk_head("rdB_c7", 64'h200);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk_head("rdB_c8", 64'h204);

    // One-cycle reset mid-stream with a request in flight.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk_head("rstC_c4", 64'h8);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 64'd0);
    chk("rstC_valid", 64'(bus.out_valid), 64'd0);
    chk("rstC_req", 64'(bus.imem_req), 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk("rstC_c0_valid", 64'(bus.out_valid), 64'd0);
    chk("rstC_c0_req", 64'(bus.imem_req), 64'd1);
    chk("rstC_c0_addr", 64'(bus.imem_addr), 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk("rstC_c1_valid", 64'(bus.out_valid), 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk_head("rstC_c2", RPC);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk_head("rstC_c3", RPC + 64'h4);

    // fetch_en low: no issue, in-flight response lands, queue drains.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("feD_req", 64'(bus.imem_req), 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
    chk_head("feD_h0", 64'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
    chk_head("feD_h1", 64'h4);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
    chk_head("feD_h2", 64'h8);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
    chk("feD_empty", 64'(bus.out_valid), 64'd0);
    chk("feD_req2", 64'(bus.imem_req), 64'd0);

    // Misaligned redirect target.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 64'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk("misE_flag", 64'(bus.out_misalign), 64'd1);
    chk("misE_req", 64'(bus.imem_req), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
      chk("misE_halt_req", 64'(bus.imem_req), 64'd0);
      chk("misE_halt_valid", 64'(bus.out_valid), 64'd0);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 64'h200);
    chk("misE_rd_req", 64'(bus.imem_req), 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk("misE_clear", 64'(bus.out_misalign), 64'd0);
    chk("misE_resume_req", 64'(bus.imem_req), 64'd1);
    chk("misE_resume_addr", 64'(bus.imem_addr), 64'h80);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk_head("misE_head", 64'h200);
`else
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk("misE_flag", 64'(bus.out_misalign), 64'd0);
    chk("misE_req", 64'(bus.imem_req), 64'd1);
    chk("misE_addr", 64'(bus.imem_addr), 64'h40);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk_head("misE_head", 64'h100);
`endif

    // Random stream: accepted PCs must form consecutive runs from RESET_PC or each redirect target.
    do_reset();
    exp_pc = RPC;
    prev_pc = '0;
    stall_prev = 1'b0;
    n_acc = 0;
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 199) == 0);
      fe  = ($urandom_range(0, 4) != 0);
      rdy = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 19) == 0);
      rpc = 64'($urandom_range(0, 1023)) << 2;
      cyc(r, fe, rdy, rv, rpc);
      if (r || rv || !fe) chk("rnd_req_blocked", 64'(bus.imem_req), 64'd0);
      if (stall_prev && !r) begin
        chk("rnd_hold_valid", 64'(bus.out_valid), 64'd1);
        chk("rnd_hold_pc", bus.out_pc, prev_pc);
      end
      if (bus.out_valid) chk("rnd_instr", 64'(bus.out_instr), 64'(word_of(bus.out_pc)));
      if (bus.out_valid && rdy) begin
        chk("rnd_pc", bus.out_pc, exp_pc);
        exp_pc = exp_pc + 64'h4;
        n_acc++;
      end
      if (rv) exp_pc = rpc;
      if (r) exp_pc = RPC;
      stall_prev = bus.out_valid && !rdy && !rv && !r;
      prev_pc = bus.out_pc;
    end
    chk("rnd_progress", 64'(n_acc > 200), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
